uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: frame-level round-robin arbiter sharing one uart_tx serializer
// between PORTS AXI-Stream byte sources. A granted source keeps the serializer
// until its tlast beat is transferred; an optional idle gap follows each frame.
// Optional feature macro: UART_ARB_SRC_ID_EN (emit a source-index header beat
// before every frame).
module uart_tx_arb #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    input  logic [GAP_W-1:0]            gap_cycles,
    output logic [PORTS-1:0]            grant,
    output logic                        busy
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

`ifdef UART_ARB_SRC_ID_EN
    if (DATA_WIDTH < $clog2(PORTS)) begin : g_hdr_width_chk
        $error("uart_tx_arb: DATA_WIDTH too narrow to carry the source index");
    end
    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_XFER, ST_DRAIN, ST_GAP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_GAP} state_t;
`endif

    state_t                  state_r, state_nx;
    logic [PORTS-1:0]        grant_r, grant_nx;
    logic [IDX_W-1:0]        gidx_r, gidx_nx;
    logic [IDX_W-1:0]        rr_r, rr_nx;
    logic [GAP_W-1:0]        gap_r, gap_nx;
    logic                    m_valid_r, m_valid_nx;
    logic [DATA_WIDTH-1:0]   m_data_r, m_data_nx;
    logic                    busy_r, busy_nx;

    logic                    win_found_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    g_valid_s;
    logic                    g_last_s;
    logic [DATA_WIDTH-1:0]   g_data_s;
    logic                    g_ready_s;
    logic                    beat_ok_s;

    function automatic logic [PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [PORTS-1:0] v;
        v = '0;
        for (int i = 0; i < PORTS; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    // Round-robin search: first valid at or above the pointer, else lowest valid below it.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!win_found_s && s_axis_tvalid[i] && (i >= int'(rr_r))) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            if (!win_found_s && s_axis_tvalid[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Select the current owner's valid/last/data.
    always_comb begin
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_data_s  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gidx_r == IDX_W'(i)) begin
                g_valid_s = s_axis_tvalid[i];
                g_last_s  = s_axis_tlast[i];
                g_data_s  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                g_valid_s = g_valid_s;
            end
        end
    end

    assign g_ready_s = !m_valid_r || m_axis_tready;
    assign beat_ok_s = (state_r == ST_XFER) && g_valid_s && g_ready_s;

    // Only the owner sees tready, and only while its frame is being moved.
    always_comb begin
        s_axis_tready = '0;
        if (state_r == ST_XFER) begin
            s_axis_tready = onehot(gidx_r) & {PORTS{g_ready_s}};
        end else begin
            s_axis_tready = '0;
        end
    end

    // Next-state and next-register values for the arbiter FSM and output stage.
    always_comb begin
        state_nx   = state_r;
        grant_nx   = grant_r;
        gidx_nx    = gidx_r;
        rr_nx      = rr_r;
        gap_nx     = gap_r;
        m_data_nx  = m_data_r;
        if (m_valid_r && m_axis_tready) begin
            m_valid_nx = 1'b0;
        end else begin
            m_valid_nx = m_valid_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_nx = onehot(win_idx_s);
                    gidx_nx  = win_idx_s;
`ifdef UART_ARB_SRC_ID_EN
                    state_nx   = ST_HDR;
                    m_valid_nx = 1'b1;
                    m_data_nx  = DATA_WIDTH'(win_idx_s);
`else
                    state_nx = ST_XFER;
`endif
                end else begin
                    state_nx = ST_IDLE;
                end
            end
`ifdef UART_ARB_SRC_ID_EN
            ST_HDR: begin
                if (m_valid_r && m_axis_tready) begin
                    state_nx = ST_XFER;
                end else begin
                    state_nx = ST_HDR;
                end
            end
`endif
            ST_XFER: begin
                if (beat_ok_s) begin
                    m_valid_nx = 1'b1;
                    m_data_nx  = g_data_s;
                    if (g_last_s) begin
                        state_nx = ST_DRAIN;
                        rr_nx    = (gidx_r == IDX_W'(PORTS - 1)) ? '0 : gidx_r + IDX_W'(1);
                    end else begin
                        state_nx = ST_XFER;
                    end
                end else begin
                    state_nx = ST_XFER;
                end
            end
            ST_DRAIN: begin
                if (!m_valid_r || m_axis_tready) begin
                    grant_nx = '0;
                    if (gap_cycles == GAP_W'(0)) begin
                        state_nx = ST_IDLE;
                    end else begin
                        gap_nx   = gap_cycles;
                        state_nx = ST_GAP;
                    end
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_GAP: begin
                gap_nx = gap_r - GAP_W'(1);
                if (gap_r <= GAP_W'(1)) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_GAP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
        busy_nx = (state_nx != ST_IDLE) || m_valid_nx;
    end

    // State and output registers; async reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            gidx_r    <= '0;
            rr_r      <= '0;
            gap_r     <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx;
            grant_r   <= grant_nx;
            gidx_r    <= gidx_nx;
            rr_r      <= rr_nx;
            gap_r     <= gap_nx;
            m_valid_r <= m_valid_nx;
            m_data_r  <= m_data_nx;
            busy_r    <= busy_nx;
        end
    end

    assign m_axis_tdata  = m_data_r;
    assign m_axis_tvalid = m_valid_r;
    assign grant         = grant_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed frames are queued per source,
// expected output bytes are pushed to exp_q, and a negedge monitor checks them.
module tb_uart_tx_arb;
    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int GW    = 16;
`ifdef UART_ARB_SRC_ID_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS-1:0]      s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]         m_tdata;
    logic                  m_tvalid, m_tready;
    logic [GW-1:0]         gap_cycles;
    logic [PORTS-1:0]      grant;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int out_cnt = 0;
    logic ready_toggle = 1'b0;
    logic [PORTS-1:0] src_fire = '0;
    logic [8:0] src_q [PORTS][$];
    logic [7:0] exp_q [$];

    uart_tx_arb #(.PORTS(PORTS), .DATA_WIDTH(DW), .GAP_W(GW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .gap_cycles(gap_cycles),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic enq(input int p, input logic [7:0] d, input logic last);
        src_q[p].push_back({last, d});
    endtask

    // first beat of a frame: header (when enabled) then data
    task automatic exp_first(input int p, input logic [7:0] d);
        if (HDR) exp_q.push_back(8'(p));
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        for (int i = 0; i < PORTS; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || busy) && k < 600) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Source driver: retire accepted beats, present next beat, drive m_tready.
    initial begin
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < PORTS; i++) begin
                logic [8:0] b;
                if (src_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                b = (src_q[i].size() > 0) ? src_q[i][0] : 9'd0;
                s_tvalid[i] = (src_q[i].size() > 0);
                s_tlast[i]  = b[8];
                s_tdata[i*DW +: DW] = b[7:0];
            end
            m_tready = ready_toggle ? ((cyc % 4) == 0) : 1'b1;
        end
    end

    // Monitor: output scoreboard, stall stability, ready ownership.
    initial begin
        logic       stall_prev;
        logic [7:0] stall_data;
        stall_prev = 1'b0;
        stall_data = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                src_fire   = '0;
                stall_prev = 1'b0;
            end else begin
                src_fire = s_tvalid & s_tready;
                check("ready_owner", 32'(s_tready & ~grant), 32'd0);
                if (stall_prev) check("stall_hold", 32'({m_tvalid, m_tdata}), 32'({1'b1, stall_data}));
                if (m_tvalid && m_tready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", m_tdata);
                    end else begin
                        check("out_byte", 32'(m_tdata), 32'(exp_q.pop_front()));
                    end
                end
                stall_prev = m_tvalid && !m_tready;
                stall_data = m_tdata;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gapc, idlec, base, k;
        logic seen0;
        gap_cycles = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(m_tvalid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 1: port 2 alone, 3-byte frame; then rr pointer = 3 decides 3 over 0
        do_reset();
        @(negedge clk);
        enq(2, 8'h11, 1'b0); enq(2, 8'h22, 1'b0); enq(2, 8'h33, 1'b1);
        exp_first(2, 8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        @(negedge clk);
        check("s1_grant_pre", 32'(grant), 32'd0);
        @(negedge clk);
        check("s1_grant", 32'(grant), 32'h4);
        if (!HDR) begin
            @(negedge clk); check("s1_b0", 32'({m_tvalid, m_tdata}), 32'h111);
            @(negedge clk); check("s1_b1", 32'({m_tvalid, m_tdata}), 32'h122);
            @(negedge clk); check("s1_b2", 32'({m_tvalid, m_tdata}), 32'h133);
            @(negedge clk); check("s1_grant_end", 32'({grant, busy}), 32'd0);
        end
        wait_drain("s1_done");
        enq(0, 8'h55, 1'b1); enq(3, 8'h44, 1'b1);
        exp_first(3, 8'h44); exp_first(0, 8'h55);
        wait_drain("s1_rr");

        // 2: all four ports, continuous 1-byte frames
        do_reset();
        @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < PORTS; p++) begin
                enq(p, 8'(8'hA0 + p), 1'b1);
                exp_first(p, 8'(8'hA0 + p));
            end
        wait_drain("s2_rr_order");

        // 3: stalled output, port 1 must wait for port 0 tlast
        do_reset();
        ready_toggle = 1'b1;
        @(negedge clk);
        enq(0, 8'hC1, 1'b0); enq(0, 8'hC2, 1'b0); enq(0, 8'hC3, 1'b0); enq(0, 8'hC4, 1'b1);
        enq(1, 8'hD1, 1'b1);
        exp_first(0, 8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
        exp_first(1, 8'hD1);
        wait_drain("s3_stall");
        ready_toggle = 1'b0;

        // 4: gap of 5 between two 1-byte frames; later gap change ignored
        do_reset();
        gap_cycles = 16'd5;
        @(negedge clk);
        enq(0, 8'h61, 1'b1); enq(1, 8'h62, 1'b1);
        exp_first(0, 8'h61); exp_first(1, 8'h62);
        gapc = 0; idlec = 0; seen0 = 1'b0; k = 0;
        while (grant != 4'b0010 && k < 200) begin
            @(negedge clk);
            k++;
            if (grant == 4'b0001) seen0 = 1'b1;
            if (seen0 && grant == 4'b0000) begin
                if (busy) gapc++;
                else idlec++;
                if (gapc == 1) gap_cycles = 16'd9;
            end
        end
        check("s4_grant1", 32'(grant), 32'h2);
        check("s4_gap_clocks", 32'(gapc), 32'd5);
        check("s4_idle_clocks", 32'(idlec), 32'd1);
        wait_drain("s4_done");
        gap_cycles = '0;

        // 5: reset after byte 2 of 4, then port 3 is granted first
        do_reset();
        @(negedge clk);
        enq(1, 8'h71, 1'b0); enq(1, 8'h72, 1'b0); enq(1, 8'h73, 1'b0); enq(1, 8'h74, 1'b1);
        exp_first(1, 8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73); exp_q.push_back(8'h74);
        base = out_cnt; k = 0;
        while ((out_cnt - base) < (HDR ? 3 : 2) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("s5_two_bytes", 32'(out_cnt - base), HDR ? 32'd3 : 32'd2);
        do_reset();
        @(negedge clk);
        enq(3, 8'h7F, 1'b1);
        exp_first(3, 8'h7F);
        k = 0;
        while (grant == 4'b0000 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("s5_first_grant", 32'(grant), 32'h8);
        wait_drain("s5_done");

        // 6: port 3 single byte (header 0x03 first when enabled)
        enq(3, 8'h55, 1'b1);
        exp_first(3, 8'h55);
        wait_drain("s6_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
